// File: rtl/key_debounce.sv
// key_debounce: synchronises raw push-button pins and filters contact bounce,
// giving a clean per-key level plus one-cycle press/release event pulses.
module key_debounce #(
  parameter int unsigned KEY_NUM         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_F = 2'd1,
    PRESSED = 2'd2,
    REL_F   = 2'd3
  } state_t;

  logic [KEY_NUM-1:0] pressed_c;
  logic [KEY_NUM-1:0] sync1;
  logic [KEY_NUM-1:0] sync2;

  // Polarity-normalise so that 1 always means "pressed"
  assign pressed_c = KEY_ACTIVE_LOW ? ~key_in : key_in;

  // Two-flop synchroniser; reset value is the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pressed_c;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < int'(KEY_NUM); i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          prs;
    logic          rel;

    // Per-channel filter FSM; a reversal while filtering falls back to the stable state
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        lvl   <= 1'b0;
        prs   <= 1'b0;
        rel   <= 1'b0;
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        unique case (state)
          IDLE: begin
            if (sync2[i]) begin
              state <= PRESS_F;
              cnt   <= '0;
            end
          end
          PRESS_F: begin
            if (!sync2[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt != CNT_LAST) begin
              cnt <= cnt + CW'(1);
            end else begin
              state <= PRESSED;
              cnt   <= '0;
              lvl   <= 1'b1;
              prs   <= 1'b1;
            end
          end
          PRESSED: begin
            if (!sync2[i]) begin
              state <= REL_F;
              cnt   <= '0;
            end
          end
          REL_F: begin
            if (sync2[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt != CNT_LAST) begin
              cnt <= cnt + CW'(1);
            end else begin
              state <= IDLE;
              cnt   <= '0;
              lvl   <= 1'b0;
              rel   <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_level[i]   = lvl;
    assign key_press[i]   = prs;
    assign key_release[i] = rel;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios plus randomized key activity, checked
// cycle by cycle against a "N+1 consecutive synchronised samples" reference.
module tb_key_debounce;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;

  key_debounce #(
    .KEY_NUM        (2),
    .DEBOUNCE_CYCLES(N),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nfail   = 0;
  int ecount  = 0;

  // reference model state
  logic [1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
  int         m_run [2];

  // per-scenario tallies taken from DUT outputs
  int np [2];
  int nr [2];
  int fp [2];
  int fr [2];

  task automatic chk(input string tag, input int got, input int exp);
    nchecks++;
    assert (got === exp)
    else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  task automatic clear_tally();
    for (int c = 0; c < 2; c++) begin
      np[c] = 0; nr[c] = 0; fp[c] = -1; fr[c] = -1;
    end
  endtask

  // One clock edge: advance the model, then compare DUT against it
  task automatic tick();
    logic s;
    @(posedge clk);
    ecount++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      m_run[0] = 0; m_run[1] = 0;
    end else begin
      m_prs = '0;
      m_rel = '0;
      for (int c = 0; c < 2; c++) begin
        s = m_s2[c];
        if (s != m_lvl[c]) m_run[c]++;
        else               m_run[c] = 0;
        if (m_run[c] == N + 1) begin
          m_lvl[c] = s;
          if (s) m_prs[c] = 1'b1;
          else   m_rel[c] = 1'b1;
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = ~key_in;
    end
    #1;
    chk("level",   int'(key_level),   int'(m_lvl));
    chk("press",   int'(key_press),   int'(m_prs));
    chk("release", int'(key_release), int'(m_rel));
    chk("press_and_release", int'(key_press & key_release), 0);
    for (int c = 0; c < 2; c++) begin
      if (key_press[c])   begin np[c]++; if (fp[c] < 0) fp[c] = ecount; end
      if (key_release[c]) begin nr[c]++; if (fr[c] < 0) fr[c] = ecount; end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int r;
    int hold [2];
    rst    = 1'b1;
    key_in = 2'b11;
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
    m_run[0] = 0; m_run[1] = 0;
    clear_tally();

    // reset state
    run(2);
    chk("reset_level", int'(key_level), 0);
    chk("reset_pulses", int'(key_press | key_release), 0);
    rst = 1'b0;
    run(6);

    // clean press on key 0
    key_in = 2'b10; r = ecount + 1; clear_tally();
    run(10);
    chk("clean_press_edge", fp[0], r + 6);
    chk("clean_press_count", np[0], 1);
    chk("clean_level", int'(key_level[0]), 1);

    // release of key 0
    key_in = 2'b11; r = ecount + 1; clear_tally();
    run(10);
    chk("release_edge", fr[0], r + 6);
    chk("release_count", nr[0], 1);
    chk("release_no_press", np[0], 0);
    chk("release_level", int'(key_level[0]), 0);

    // bounce: 3 low, 1 high, then low held
    clear_tally();
    key_in = 2'b10; run(3);
    key_in = 2'b11; run(1);
    key_in = 2'b10; r = ecount + 1;
    run(10);
    chk("bounce_press_edge", fp[0], r + 6);
    chk("bounce_press_count", np[0], 1);
    key_in = 2'b11; run(10);

    // independence: both pressed at the same edge, then release key 1 only
    key_in = 2'b00; r = ecount + 1; clear_tally();
    run(10);
    chk("both_press_edge0", fp[0], r + 6);
    chk("both_press_edge1", fp[1], r + 6);
    key_in = 2'b10; r = ecount + 1; clear_tally();
    run(10);
    chk("rel1_edge", fr[1], r + 6);
    chk("rel1_no_rel0", nr[0], 0);
    chk("rel1_level", int'(key_level), 2'b01);
    key_in = 2'b11; run(10);

    // reset while key 0 is mid-filter (cnt=2), key still held
    key_in = 2'b10; run(5);
    rst = 1'b1; tick();
    chk("midrst_level", int'(key_level), 0);
    chk("midrst_pulses", int'(key_press | key_release), 0);
    rst = 1'b0; r = ecount + 1; clear_tally();
    run(10);
    chk("midrst_press_edge", fp[0], r + 6);
    chk("midrst_press_count", np[0], 1);

    // reset while pressed, key released during reset: no release pulse
    rst = 1'b1; key_in = 2'b11; clear_tally();
    tick();
    rst = 1'b0;
    run(12);
    chk("prst_no_release", nr[0], 0);
    chk("prst_no_press", np[0], 0);
    chk("prst_level", int'(key_level[0]), 0);

    // randomized activity with occasional resets
    hold[0] = 0; hold[1] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          key_in[c] = 1'($urandom_range(0, 1));
          hold[c] = (($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 14))
                                                 : int'($urandom_range(1, 5)));
        end
        hold[c]--;
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", nchecks - nfail, nchecks);
    $finish;
  end

endmodule
